// File: rtl/fetch_ctrl.sv
// Fetch-stage front-end sequencer: PC/IR hold, IF/ID kill and PC source select
// from ID decode and hazard inputs, plus saturating redirect/stall counters.
module fetch_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int LAT_W    = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             jump_D,
  input  logic             jr_D,
  input  logic             rs_ready_D,
  input  logic             load_use_D,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             disable_PC,
  output logic             disable_IR,
  output logic             KILL,
  output logic [1:0]       PCsrc,
  output logic             stall_D,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_STALL   = 2'b01;
  localparam logic [1:0] ST_WAIT_RS = 2'b10;
  localparam logic [1:0] ST_KILLED  = 2'b11;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_OFFSET = 2'b01;
  localparam logic [1:0] PC_REGRS  = 2'b10;

  localparam logic [LAT_W-1:0] LAT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [1:0]       state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [CNT_W-1:0] redirect_q, redirect_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             redirect_s;

  // Mealy output decode and next-state selection
  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    redirect_s = 1'b0;
    disable_PC = 1'b0;
    disable_IR = 1'b0;
    KILL       = 1'b0;
    PCsrc      = PC_SEQ;
    stall_D    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (load_use_D) begin
          disable_PC = 1'b1;
          disable_IR = 1'b1;
          stall_D    = 1'b1;
          // the detection cycle is the first stall cycle
          if (LOAD_LAT > 1) begin
            lat_d   = LAT_INIT;
            state_d = ST_STALL;
          end else begin
            state_d = ST_RUN;
          end
        end else if (jr_D && !rs_ready_D) begin
          disable_PC = 1'b1;
          disable_IR = 1'b1;
          stall_D    = 1'b1;
          state_d    = ST_WAIT_RS;
        end else if (jr_D) begin
          KILL       = 1'b1;
          PCsrc      = PC_REGRS;
          redirect_s = 1'b1;
          state_d    = ST_KILLED;
        end else if (jump_D) begin
          KILL       = 1'b1;
          PCsrc      = PC_OFFSET;
          redirect_s = 1'b1;
          state_d    = ST_KILLED;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STALL: begin
        disable_PC = 1'b1;
        disable_IR = 1'b1;
        stall_D    = 1'b1;
        if (lat_q == LAT_ONE) begin
          state_d = ST_RUN;
        end else begin
          lat_d = lat_q - LAT_ONE;
        end
      end
      ST_WAIT_RS: begin
        if (rs_ready_D) begin
          KILL       = 1'b1;
          PCsrc      = PC_REGRS;
          redirect_s = 1'b1;
          state_d    = ST_KILLED;
        end else begin
          disable_PC = 1'b1;
          disable_IR = 1'b1;
          stall_D    = 1'b1;
        end
      end
      ST_KILLED: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    // a memory freeze (or reset) overrides everything and holds all state
    if (!reset || mem_busy) begin
      disable_PC = 1'b1;
      disable_IR = 1'b1;
      KILL       = 1'b0;
      PCsrc      = PC_SEQ;
      stall_D    = 1'b0;
      redirect_s = 1'b0;
      state_d    = state_q;
      lat_d      = lat_q;
    end else begin
      state_d = state_d;
    end
  end

  // Saturating performance counters with synchronous clear priority
  always_comb begin
    redirect_d = redirect_q;
    stall_d    = stall_q;
    if (cnt_clr) begin
      redirect_d = CNT_ZERO;
      stall_d    = CNT_ZERO;
    end else begin
      if (redirect_s && (redirect_q != CNT_MAX)) begin
        redirect_d = redirect_q + CNT_ONE;
      end else begin
        redirect_d = redirect_q;
      end
      if (stall_D && (stall_q != CNT_MAX)) begin
        stall_d = stall_q + CNT_ONE;
      end else begin
        stall_d = stall_q;
      end
    end
  end

  // State, latency and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      lat_q      <= {LAT_W{1'b0}};
      redirect_q <= CNT_ZERO;
      stall_q    <= CNT_ZERO;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      redirect_q <= redirect_d;
      stall_q    <= stall_d;
    end
  end

  assign state        = state_q;
  assign redirect_cnt = redirect_q;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random stimulus
// against a counting reference model of the fetch sequencing rules.
module tb_fetch_ctrl;
  localparam int LOAD_LAT = 3;
  localparam int CNT_W    = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic jump_D = 1'b0, jr_D = 1'b0, rs_ready_D = 1'b0, load_use_D = 1'b0;
  logic mem_busy = 1'b0, cnt_clr = 1'b0;
  logic disable_PC, disable_IR, KILL, stall_D;
  logic [1:0] PCsrc, state;
  logic [CNT_W-1:0] redirect_cnt, stall_cnt;

  fetch_ctrl #(.LOAD_LAT(LOAD_LAT), .LAT_W(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .jump_D(jump_D), .jr_D(jr_D), .rs_ready_D(rs_ready_D),
    .load_use_D(load_use_D), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .disable_PC(disable_PC), .disable_IR(disable_IR), .KILL(KILL), .PCsrc(PCsrc),
    .stall_D(stall_D), .state(state), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  wire [15:0] obs = {disable_PC, disable_IR, KILL, PCsrc, stall_D, state, redirect_cnt, stall_cnt};

  int errors = 0;
  int checks = 0;

  // model: pending stall cycles, waiting-for-operand flag, killed-slot flag, counts
  int m_left = 0, m_wait = 0, m_killed = 0, m_redir = 0, m_stalls = 0;
  int n_left, n_wait, n_killed, n_redir, n_stalls;
  logic [15:0] exp_v;

  task automatic apply(input logic rst, input logic ju, input logic jr, input logic rdy,
                       input logic lu, input logic mb, input logic clr);
    logic [7:0] o;
    logic [1:0] st;
    bit hold, rinc;
    reset = rst; jump_D = ju; jr_D = jr; rs_ready_D = rdy;
    load_use_D = lu; mem_busy = mb; cnt_clr = clr;
    if (!rst) begin
      m_left = 0; m_wait = 0; m_killed = 0; m_redir = 0; m_stalls = 0;
    end
    st = (m_killed != 0) ? 2'd3 : (m_wait != 0) ? 2'd2 : (m_left > 0) ? 2'd1 : 2'd0;
    n_left = m_left; n_wait = m_wait; n_killed = m_killed;
    n_redir = m_redir; n_stalls = m_stalls;
    hold = 1'b0; rinc = 1'b0;
    o = 8'b11_0_00_0_00;
    if (!rst || mb) begin
      o = 8'b11_0_00_0_00;
    end else if (m_killed != 0) begin
      o = 8'b00_0_00_0_00; n_killed = 0;
    end else if (m_left > 0) begin
      hold = 1'b1; n_left = m_left - 1;
    end else if (m_wait != 0) begin
      if (rdy) begin
        o = 8'b00_1_10_0_00; rinc = 1'b1; n_wait = 0; n_killed = 1;
      end else begin
        hold = 1'b1;
      end
    end else if (lu) begin
      hold = 1'b1; n_left = LOAD_LAT - 1;
    end else if (jr && !rdy) begin
      hold = 1'b1; n_wait = 1;
    end else if (jr) begin
      o = 8'b00_1_10_0_00; rinc = 1'b1; n_killed = 1;
    end else if (ju) begin
      o = 8'b00_1_01_0_00; rinc = 1'b1; n_killed = 1;
    end else begin
      o = 8'b00_0_00_0_00;
    end
    if (hold) o = 8'b11_0_00_1_00;
    o[1:0] = st;
    if (clr) begin
      n_redir = 0; n_stalls = 0;
    end else begin
      if (rinc && m_redir < CMAX) n_redir = m_redir + 1;
      if (hold && m_stalls < CMAX) n_stalls = m_stalls + 1;
    end
    if (!rst) begin
      n_left = 0; n_wait = 0; n_killed = 0; n_redir = 0; n_stalls = 0;
    end
    exp_v = {o, 4'(m_redir), 4'(m_stalls)};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_left = n_left; m_wait = n_wait; m_killed = n_killed;
    m_redir = n_redir; m_stalls = n_stalls;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; #2;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      if (i > 0) begin
        checks++;
        if (obs !== exp_v || obs !== 16'hC000) begin
          errors++; $display("FAIL reset_freeze cyc%0d got=%h exp=%h", i, obs, exp_v);
        end
      end
      tick();
    end
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== 16'h0000) begin
      errors++; $display("FAIL reset_release got=%h exp=0000", obs);
    end
    tick();
  endtask

  task automatic test_load_use();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0, (i == 0), 1'b0, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL load_use cyc%0d got=%h exp=%h", i, obs, exp_v);
      end
      tick();
    end
    checks++;
    if (stall_cnt !== 4'd3 || state !== 2'b00) begin
      errors++; $display("FAIL load_use_total stall_cnt=%0d state=%b exp 3/00", stall_cnt, state);
    end
  endtask

  task automatic test_jr_wait();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 7; i++) begin
      apply(1'b1, 1'b0, (i < 5), (i == 4), 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL jr_wait cyc%0d got=%h exp=%h", i, obs, exp_v);
      end
      tick();
    end
    checks++;
    if (redirect_cnt !== 4'd1 || stall_cnt !== 4'd4) begin
      errors++; $display("FAIL jr_wait_cnt redir=%0d stall=%0d exp 1/4", redirect_cnt, stall_cnt);
    end
  endtask

  task automatic test_jump_vs_load_use();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0, (i == 0), 1'b0, 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL jump_lu cyc%0d got=%h exp=%h", i, obs, exp_v);
      end
      if (i == 3 && (PCsrc !== 2'b01 || KILL !== 1'b1)) begin
        errors++; $display("FAIL jump_lu_redirect PCsrc=%b KILL=%b exp 01/1", PCsrc, KILL);
      end
      tick();
    end
    checks++;
    if (redirect_cnt !== 4'd2) begin
      errors++; $display("FAIL jump_lu_cnt redir=%0d exp 2", redirect_cnt);
    end
  endtask

  task automatic test_freeze_in_stall();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 9; i++) begin
      apply(1'b1, 1'b0, 1'b0, 1'b0, (i == 0), (i >= 1 && i <= 5), 1'b0);
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL freeze cyc%0d got=%h exp=%h", i, obs, exp_v);
      end
      tick();
    end
    checks++;
    if (stall_cnt !== 4'd3) begin
      errors++; $display("FAIL freeze_stall_cnt got=%0d exp 3", stall_cnt);
    end
  endtask

  task automatic test_saturation();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
      apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    end
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (redirect_cnt !== 4'd15 || obs !== exp_v) begin
      errors++; $display("FAIL saturate redir=%0d got=%h exp=%h", redirect_cnt, obs, exp_v);
    end
    tick();
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    checks++;
    if (redirect_cnt !== 4'd0 || state !== 2'b11) begin
      errors++; $display("FAIL clr_wins redir=%0d state=%b exp 0/11", redirect_cnt, state);
    end
  endtask

  task automatic test_reset_mid_stall();
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== 16'hC000) begin
      errors++; $display("FAIL reset_mid_stall got=%h exp=c000", obs);
    end
    tick();
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_v || PCsrc !== 2'b01) begin
      errors++; $display("FAIL reset_then_run got=%h exp=%h", obs, exp_v);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 40) == 0));
      checks++;
      if (obs !== exp_v) begin
        errors++; $display("FAIL random cyc%0d got=%h exp=%h", i, obs, exp_v);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_jr_wait();
    test_jump_vs_load_use();
    test_freeze_in_stall();
    test_saturation();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
